pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_slice.sv | 34 +++
 rtl/pipe_chain.sv | 97 +++++++++
 tb/tb_pipe_chain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_chain register pipeline.
package pipe_pkg;
  localparam int DEF_W      = 32;
  localparam int DEF_STAGES = 4;
  localparam int DEF_CW     = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/pipe_slice.sv
// One pipeline stage: a valid bit plus a W-bit payload register.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_kill,
  input  logic         i_vld,
  input  logic         i_data_ld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);
  logic         r_vld;
  logic [W-1:0] r_data;

  // A held stage only ever loses its valid bit; its payload stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_load) r_vld <= i_vld;
      else        r_vld <= r_vld & ~i_kill;
      if (i_load && i_data_ld) r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
endmodule

// File: rtl/pipe_chain.sv
// Elastic register pipeline with per-stage stall, prefix flush and bubble collapse.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int STAGES = DEF_STAGES,
  parameter int CW     = DEF_CW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W-1:0]                   in_data,
  input  logic [STAGES-1:0]              stall_req,
  input  logic [STAGES-1:0]              flush_req,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   out_data,
  output logic [STAGES-1:0]              stage_valid,
  output logic [clog2(STAGES+1)-1:0]     occupancy,
  output logic [CW-1:0]                  stall_cnt
);
  localparam int OW = clog2(STAGES + 1);

  logic [STAGES-1:0] w_vld;
  logic [STAGES-1:0] w_kill;
  logic [STAGES-1:0] w_take;
  logic [STAGES-1:0] w_move;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_dld;
  logic [W-1:0]      w_din  [STAGES];
  logic [W-1:0]      w_data [STAGES];
  logic [CW-1:0]     r_stall_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < STAGES; i++) w_kill[i] = |(flush_req >> i);
  end

  // Ready ripples from the consumer toward the producer, one stage at a time.
  always_comb begin
    logic t;
    t      = out_ready;
    w_take = '0;
    w_move = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_move[i] = w_vld[i] & ~stall_req[i] & t;
      w_take[i] = ~stall_req[i] & (~w_vld[i] | w_move[i]);
      t         = w_take[i];
    end
  end

  always_comb begin
    w_vin[0] = in_valid & ~w_kill[0];
    w_dld[0] = in_valid;
    w_din[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_vin[i] = w_vld[i-1] & ~stall_req[i-1] & ~w_kill[i-1];
      w_dld[i] = 1'b1;
      w_din[i] = w_data[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_slice #(.W(W)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_take[g]),
      .i_kill    (w_kill[g]),
      .i_vld     (w_vin[g]),
      .i_data_ld (w_dld[g]),
      .i_data    (w_din[g]),
      .o_vld     (w_vld[g]),
      .o_data    (w_data[g])
    );
  end

  assign in_ready    = ~rst & w_take[0] & ~w_kill[0];
  assign out_valid   = ~rst & w_vld[STAGES-1] & ~stall_req[STAGES-1] & ~w_kill[STAGES-1];
  assign out_data    = w_data[STAGES-1];
  assign stage_valid = w_vld;
  assign stall_cnt   = r_stall_cnt;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OW'(w_vld[i]);
  end

  // Counts cycles where work is in flight but nothing is offered downstream.
  always_ff @(posedge clk) begin
    if (rst)                      r_stall_cnt <= '0;
    else if (~out_valid & |w_vld) r_stall_cnt <= sat_inc(r_stall_cnt);
  end
endmodule

// File: tb/tb_pipe_chain.sv
// Bench for pipe_chain: vector table, directed corner sequences, randomized model comparison.
module tb_pipe_chain;
  localparam int W      = 32;
  localparam int STAGES = 4;
  localparam int CW     = 4;
  localparam int OW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_data = '0;
  logic [STAGES-1:0] stall_req = '0;
  logic [STAGES-1:0] flush_req = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [STAGES-1:0] stage_valid;
  logic [OW-1:0]     occupancy;
  logic [CW-1:0]     stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] got [$];
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  pipe_chain #(.W(W), .STAGES(STAGES), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic iv, input logic [W-1:0] d,
                       input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl,
                       input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; stall_req = st; flush_req = fl; out_ready = ordy;
    #1;
  endtask

  task automatic reset_seq();
    drive(1'b1, 1'b1, 32'hDEADBEEF, '0, '0, 1'b1);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    drive(1'b1, 1'b0, '0, '0, '0, 1'b1);
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_stage_valid", 64'(stage_valid), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
  endtask

  task automatic drain(input int max);
    got.delete();
    for (int c = 0; c < max; c++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (out_valid) got.push_back(out_data);
    end
  endtask

  task automatic chk_order(input string nm);
    chk({nm, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_item%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         e_ov;
    logic [W-1:0] e_od;
    int           e_occ;
    logic         e_ir;
    int           e_cnt;
  } vec_t;
  vec_t tbl [13];

  // Behavioural model state for the randomized phase.
  logic         m_v [STAGES];
  logic [W-1:0] m_d [STAGES];
  int           m_cnt;

  initial begin
    // Fill: 0x1..0x8 back-to-back with the consumer always ready.
    tbl[0]  = '{1'b1, 32'h1, 1'b0, 32'h0, 0, 1'b1, 0};
    tbl[1]  = '{1'b1, 32'h2, 1'b0, 32'h0, 1, 1'b1, 0};
    tbl[2]  = '{1'b1, 32'h3, 1'b0, 32'h0, 2, 1'b1, 1};
    tbl[3]  = '{1'b1, 32'h4, 1'b0, 32'h0, 3, 1'b1, 2};
    tbl[4]  = '{1'b1, 32'h5, 1'b1, 32'h1, 4, 1'b1, 3};
    tbl[5]  = '{1'b1, 32'h6, 1'b1, 32'h2, 4, 1'b1, 3};
    tbl[6]  = '{1'b1, 32'h7, 1'b1, 32'h3, 4, 1'b1, 3};
    tbl[7]  = '{1'b1, 32'h8, 1'b1, 32'h4, 4, 1'b1, 3};
    tbl[8]  = '{1'b0, 32'h0, 1'b1, 32'h5, 4, 1'b1, 3};
    tbl[9]  = '{1'b0, 32'h0, 1'b1, 32'h6, 3, 1'b1, 3};
    tbl[10] = '{1'b0, 32'h0, 1'b1, 32'h7, 2, 1'b1, 3};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 32'h8, 1, 1'b1, 3};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b1, 3};

    reset_seq();
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, tbl[i].iv, tbl[i].d, '0, '0, 1'b1);
      chk($sformatf("fill%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("fill%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_od));
      chk($sformatf("fill%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("fill%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("fill%0d_stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_cnt));
    end

    // Backpressure from the consumer: full pipe holds, nothing lost.
    reset_seq();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 32'h11 + k, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'h99, '0, '0, 1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_occ", 64'(occupancy), 64'(4));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
    end
    drain(8);
    exp_q = '{32'h11, 32'h12, 32'h13, 32'h14};
    chk_order("bp");

    // Output stage stalled: counter advances 5, then saturates at 15.
    reset_seq();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 32'h21 + k, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'h77, 4'b1000, '0, 1'b1);
      chk("st_out_valid", 64'(out_valid), 64'(0));
      chk("st_in_ready", 64'(in_ready), 64'(0));
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("st_cnt_plus5", 64'(stall_cnt), 64'(8));
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b0, '0, 4'b1000, '0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("st_cnt_sat", 64'(stall_cnt), 64'(15));
    drain(8);
    exp_q = '{32'h21, 32'h22, 32'h23, 32'h24};
    chk_order("st");

    // Bubble collapse: stages {A@2, B@0} with holes close up under backpressure.
    reset_seq();
    drive(1'b0, 1'b1, 32'hA, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hB, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hC, '0, '0, 1'b0);
    chk("bub_sv_before", 64'(stage_valid), 64'(4'b0101));
    chk("bub_in_ready", 64'(in_ready), 64'(1));
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("bub_sv_after", 64'(stage_valid), 64'(4'b1011));
    drain(10);
    exp_q = '{32'hA, 32'hB, 32'hC};
    chk_order("bub");

    // Flush of stages 0..1 while D, C sit in stages 3, 2.
    reset_seq();
    drive(1'b0, 1'b1, 32'hD4, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hC3, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hB2, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hA1, '0, '0, 1'b0);
    drive(1'b0, 1'b1, 32'hEE, '0, 4'b0010, 1'b1);
    chk("fl_in_ready", 64'(in_ready), 64'(0));
    chk("fl_out_valid", 64'(out_valid), 64'(1));
    chk("fl_out_data", 64'(out_data), 64'(32'hD4));
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("fl_sv", 64'(stage_valid), 64'(4'b1000));
    chk("fl_out_data2", 64'(out_data), 64'(32'hC3));
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("fl_empty", 64'(stage_valid), 64'(0));

    // Stall on stage 2 together with a full flush.
    reset_seq();
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 32'h40 + k, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 4'b0100, 4'b1000, 1'b1);
    chk("sf_out_valid", 64'(out_valid), 64'(0));
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("sf_sv", 64'(stage_valid), 64'(0));
    chk("sf_out_valid2", 64'(out_valid), 64'(0));

    // Reset mid-stream with three payloads in flight.
    reset_seq();
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 32'h60 + k, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b1);
    chk("mr_in_ready", 64'(in_ready), 64'(0));
    chk("mr_out_valid", 64'(out_valid), 64'(0));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
      chk("mr_occ", 64'(occupancy), 64'(0));
      chk("mr_cnt", 64'(stall_cnt), 64'(0));
      chk("mr_out_valid_idle", 64'(out_valid), 64'(0));
    end
    drive(1'b0, 1'b1, 32'h55, '0, '0, 1'b1);
    drain(6);
    exp_q = '{32'h55};
    chk_order("mr");

    // Randomized traffic against the behavioural model.
    reset_seq();
    for (int i = 0; i < STAGES; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
    m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic              r, iv, ordy, e_ov, e_ir, any;
      logic [W-1:0]      d;
      logic [STAGES-1:0] st, fl, e_sv;
      logic              ok [STAGES+1];
      int                e_occ;
      r    = ($urandom_range(0, 99) == 0);
      iv   = $urandom_range(0, 1) == 1;
      d    = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < STAGES; i++) st[i] = ($urandom_range(0, 5) == 0);
      fl   = ($urandom_range(0, 15) == 0) ? STAGES'($urandom_range(1, 15)) : '0;
      drive(r, iv, d, st, fl, ordy);

      ok[STAGES] = ordy;
      for (int i = STAGES - 1; i >= 0; i--)
        ok[i] = !st[i] && (!m_v[i] || (!st[i] && ok[i+1]));
      e_ov = !r && m_v[STAGES-1] && !st[STAGES-1] && ((fl >> (STAGES-1)) == 0);
      e_ir = !r && ok[0] && (fl == 0);
      e_occ = 0;
      any = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        e_sv[i] = m_v[i];
        e_occ += int'(m_v[i]);
        any |= m_v[i];
      end
      chk("rnd_out_valid", 64'(out_valid), 64'(e_ov));
      chk("rnd_in_ready", 64'(in_ready), 64'(e_ir));
      chk("rnd_stage_valid", 64'(stage_valid), 64'(e_sv));
      chk("rnd_occ", 64'(occupancy), 64'(e_occ));
      chk("rnd_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("rnd_out_data", 64'(out_data), 64'(m_d[STAGES-1]));

      if (r) begin
        for (int i = 0; i < STAGES; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
        m_cnt = 0;
      end else begin
        if (!e_ov && any && m_cnt < 15) m_cnt++;
        for (int i = STAGES - 1; i >= 0; i--) begin
          if (!ok[i]) m_v[i] = m_v[i] && ((fl >> i) == 0);
          else if (i == 0) begin
            m_v[0] = iv && (fl == 0);
            if (iv) m_d[0] = d;
          end else begin
            m_v[i] = m_v[i-1] && !st[i-1] && ((fl >> (i-1)) == 0);
            m_d[i] = m_d[i-1];
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
